// File: rtl/aes_gcm_ctr_block_gen_pkg.sv
// Shared types for the AES-GCM stage-2 counter block generator: phase codes,
// output word kinds, FSM states and the FIFO entry layout.
package aes_gcm_pkg;

   localparam logic [2:0] PH_IDLE  = 3'b100;
   localparam logic [2:0] PH_AAD   = 3'b010;
   localparam logic [2:0] PH_FIRST = 3'b000;
   localparam logic [2:0] PH_TEXT  = 3'b001;
   localparam logic [2:0] PH_LAST  = 3'b011;
   localparam logic [2:0] PH_ONLY  = 3'b111;

   localparam logic [31:0] J0_CTR = 32'd1;

   typedef enum logic [1:0] {
      KIND_AAD     = 2'b00,
      KIND_TEXT    = 2'b01,
      KIND_TAGMASK = 2'b10
   } kind_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AAD,
      ST_TEXT,
      ST_TAG
   } state_t;

   typedef struct packed {
      logic [127:0] ctr_block;
      logic [127:0] data;
      kind_t        kind;
      logic         last;
   } fifo_entry_t;

   function automatic logic [127:0] j0_block(input logic [95:0] iv);
      return {iv, J0_CTR};
   endfunction

endpackage

// File: rtl/aes_gcm_ctr_block_gen_if.sv
// Output stream towards the AES round core: one counter block plus its data
// word per valid/ready handshake.
interface aes_gcm_ctr_block_gen_if;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_ctr_block;
   logic [127:0] o_data;
   logic [1:0]   o_kind;
   logic         o_last;

   modport master (
      output o_valid, o_ctr_block, o_data, o_kind, o_last,
      input  i_ready
   );

   modport slave (
      input  o_valid, o_ctr_block, o_data, o_kind, o_last,
      output i_ready
   );
endinterface

// File: rtl/aes_gcm_ctr_block_gen_fifo.sv
// gcm_ctr_fifo: DEPTH-entry FIFO with two write ports and one read port.
// Port 1 lands behind port 0 when both write in the same cycle; caller guarantees space.
module gcm_ctr_fifo
   import aes_gcm_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en0,
   input  fifo_entry_t              wr_data0,
   input  logic                     wr_en1,
   input  fifo_entry_t              wr_data1,
   input  logic                     rd_en,
   output fifo_entry_t              rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     free2
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   fifo_entry_t   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] wptr1;
   logic [AW-1:0] rptr;

   always_comb begin
      wptr1   = wptr + AW'(wr_en0);
      rd_data = mem[rptr];
      empty   = (count == '0);
      full    = (count == CW'(DEPTH));
      free2   = (count <= CW'(DEPTH - 2));
   end

   always_ff @(posedge clk) begin
      if (wr_en0) mem[wptr]  <= wr_data0;
      if (wr_en1) mem[wptr1] <= wr_data1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr + AW'(wr_en0) + AW'(wr_en1);
         rptr  <= rptr + AW'(rd_en);
         count <= count + CW'(wr_en0) + CW'(wr_en1) - CW'(rd_en);
      end
   end

endmodule

// File: rtl/aes_gcm_ctr_block_gen.sv
// AES-GCM stage 2: builds IV||ctr32 counter blocks, tags words AAD/TEXT/TAGMASK and
// appends a J0 block per instance. Optional GCM_STATS_EN adds popped/dropped counters.
module aes_gcm_ctr_block_gen
   import aes_gcm_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] CTR_INIT = 32'd2
) (
   input  logic                          clk,
   input  logic                          i_rst_n,
   input  logic [127:0]                  i_counter,
   input  logic [2:0]                    i_phase,
   input  logic [127:0]                  i_plain_text,
   input  logic [127:0]                  i_aad,
   input  logic [95:0]                   i_iv,
   input  logic [127:0]                  i_instance_size,
   aes_gcm_ctr_block_gen_if.master       out_if,
   output logic                          o_overflow
`ifdef GCM_STATS_EN
   ,
   output logic [31:0]                   o_blk_count,
   output logic [31:0]                   o_drop_count
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   state_t        state;
   state_t        state_nxt;
   logic [95:0]   tag_iv;
   logic [63:0]   aad_blocks;
   logic [127:0]  text_idx;
   logic [31:0]   ctr32;
   logic          word_vld;
   logic          word_last;
   logic          word_ok;
   logic          j0_push;
   logic          pop;
   logic [1:0]    need;
   logic          avail1;
   logic          avail2;
   logic          avail3;
   logic          fits;
   fifo_entry_t   word;
   fifo_entry_t   j0_word;
   fifo_entry_t   wr_data0;
   fifo_entry_t   head;
   logic          wr_en0;
   logic          wr_en1;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          free2;
   logic          unused_bits;

   // Size bits are MSB-first: the AAD length occupies the upper 64 bits.
   assign unused_bits = ^{i_instance_size[63:0], text_idx[127:32]};

   always_comb begin
      aad_blocks = i_instance_size[127:64] >> 7;
      text_idx   = i_counter - {64'd0, aad_blocks};
      ctr32      = CTR_INIT + text_idx[31:0];

      word      = '0;
      word_vld  = 1'b1;
      word_last = 1'b0;
      case (i_phase)
         PH_AAD: begin
            word.ctr_block = {i_iv, 32'd0};
            word.data      = i_aad;
            word.kind      = KIND_AAD;
         end
         PH_FIRST, PH_TEXT: begin
            word.ctr_block = {i_iv, ctr32};
            word.data      = i_plain_text;
            word.kind      = KIND_TEXT;
         end
         PH_LAST, PH_ONLY: begin
            word.ctr_block = {i_iv, ctr32};
            word.data      = i_plain_text;
            word.kind      = KIND_TEXT;
            word_last      = 1'b1;
         end
         default: word_vld = 1'b0;
      endcase

      j0_push = (state == ST_TAG);
      j0_word = '{ctr_block: j0_block(tag_iv), data: '0, kind: KIND_TAGMASK, last: 1'b1};
      pop     = !empty && out_if.i_ready;

      // A last-text word reserves a slot for its J0 so the TAG cycle can never overflow.
      need   = (word_last ? 2'd2 : 2'd1) + (j0_push ? 2'd1 : 2'd0);
      avail1 = !full || pop;
      avail2 = free2 || (pop && !full);
      avail3 = (int'(count) + 3) <= (int'(DEPTH) + int'(pop));
      case (need)
         2'd1:    fits = avail1;
         2'd2:    fits = avail2;
         default: fits = avail3;
      endcase
      word_ok = word_vld && fits;

      wr_en0   = j0_push || word_ok;
      wr_data0 = j0_push ? j0_word : word;
      wr_en1   = j0_push && word_ok;

      state_nxt = (state == ST_TAG) ? ST_IDLE : state;
      case (i_phase)
         PH_AAD:           state_nxt = ST_AAD;
         PH_FIRST:         state_nxt = ST_TEXT;
         // A dropped last word also drops its J0, so skip the TAG state entirely.
         PH_LAST, PH_ONLY: state_nxt = word_ok ? ST_TAG : ST_IDLE;
         default:          ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state      <= ST_IDLE;
         tag_iv     <= '0;
         o_overflow <= 1'b0;
      end else begin
         state <= state_nxt;
         if (word_ok && word_last) tag_iv <= i_iv;
         if (word_vld && !word_ok) o_overflow <= 1'b1;
      end
   end

   gcm_ctr_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (i_rst_n),
      .wr_en0   (wr_en0),
      .wr_data0 (wr_data0),
      .wr_en1   (wr_en1),
      .wr_data1 (word),
      .rd_en    (pop),
      .rd_data  (head),
      .count    (count),
      .empty    (empty),
      .full     (full),
      .free2    (free2)
   );

   assign out_if.o_valid     = !empty;
   assign out_if.o_ctr_block = empty ? '0 : head.ctr_block;
   assign out_if.o_data      = empty ? '0 : head.data;
   assign out_if.o_kind      = empty ? 2'b00 : head.kind;
   assign out_if.o_last      = !empty && head.last;

`ifdef GCM_STATS_EN
   logic [1:0]  drop_n;
   logic [32:0] drop_sum;

   always_comb begin
      drop_n   = (word_vld && !word_ok) ? (word_last ? 2'd2 : 2'd1) : 2'd0;
      drop_sum = {1'b0, o_drop_count} + 33'(drop_n);
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         o_blk_count  <= '0;
         o_drop_count <= '0;
      end else begin
         if (pop && (o_blk_count != '1)) o_blk_count <= o_blk_count + 32'd1;
         o_drop_count <= drop_sum[32] ? '1 : drop_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_aes_gcm_ctr_block_gen.sv
// Directed bench for aes_gcm_ctr_block_gen: hand-computed counter blocks, kinds,
// J0 insertion, overflow, wrap and reset behaviour.
module tb_aes_gcm_ctr_block_gen;
   import aes_gcm_pkg::*;

   localparam logic [95:0] IV_A = 96'hCAFEBABE_0000FACE_12345678;
   localparam logic [95:0] IV_B = 96'h0BADF00D_11223344_55667788;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] counter;
   logic [2:0]   phase;
   logic [127:0] pt;
   logic [127:0] aad;
   logic [95:0]  iv;
   logic [127:0] isize;
   logic         overflow;
`ifdef GCM_STATS_EN
   logic [31:0]  blk_count;
   logic [31:0]  drop_count;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [127:0] cb;
      logic [127:0] d;
      logic [1:0]   k;
      logic         l;
   } rec_t;
   rec_t cap[$];

   aes_gcm_ctr_block_gen_if bus ();

   aes_gcm_ctr_block_gen #(
      .DEPTH    (4),
      .CTR_INIT (32'd2)
   ) dut (
      .clk             (clk),
      .i_rst_n         (rst_n),
      .i_counter       (counter),
      .i_phase         (phase),
      .i_plain_text    (pt),
      .i_aad           (aad),
      .i_iv            (iv),
      .i_instance_size (isize),
      .out_if          (bus),
      .o_overflow      (overflow)
`ifdef GCM_STATS_EN
      ,
      .o_blk_count     (blk_count),
      .o_drop_count    (drop_count)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst_n && bus.o_valid && bus.i_ready)
         cap.push_back('{bus.o_ctr_block, bus.o_data, bus.o_kind, bus.o_last});

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] ph, input logic [127:0] ctr,
                        input logic [127:0] aw, input logic [127:0] tw);
      phase   = ph;
      counter = ctr;
      aad     = aw;
      pt      = tw;
      tick();
      phase   = PH_IDLE;
   endtask

   task automatic idle(input int n);
      phase = PH_IDLE;
      repeat (n) tick();
   endtask

   task automatic exp_rec(input string tag, input int idx, input logic [127:0] cb,
                          input logic [127:0] d, input logic [1:0] k, input logic l);
      rec_t r;
      if (idx < cap.size()) r = cap[idx];
      else r = '{cb: 'x, d: 'x, k: 'x, l: 1'bx};
      chk({tag, ".ctr"}, r.cb, cb);
      chk({tag, ".data"}, r.d, d);
      chk({tag, ".kind_last"}, 128'({r.k, r.l}), 128'({k, l}));
   endtask

   initial begin
      rst_n = 1'b0; phase = PH_IDLE; counter = '0; pt = '0; aad = '0;
      iv = IV_A; isize = '0; bus.i_ready = 1'b0;
      repeat (3) tick();
      chk("rst.valid", 128'(bus.o_valid), 128'(1'b0));
      chk("rst.ctr", bus.o_ctr_block, 128'd0);
      chk("rst.data", bus.o_data, 128'd0);
      chk("rst.kind_last", 128'({bus.o_kind, bus.o_last}), 128'(3'b000));
      chk("rst.overflow", 128'(overflow), 128'(1'b0));
      rst_n = 1'b1; bus.i_ready = 1'b1;
      tick();

      // 1: 2 AAD blocks + 3 text blocks, then J0
      cap.delete(); iv = IV_A; isize = {64'd256, 64'd384};
      drive(PH_AAD, 128'd0, 128'hA0, 128'hF0);
      chk("t1.latency", 128'(bus.o_valid), 128'(1'b1));
      drive(PH_AAD,   128'd1, 128'hA1, 128'hF1);
      drive(PH_FIRST, 128'd2, 128'hA2, 128'hD0);
      drive(PH_TEXT,  128'd3, 128'hA3, 128'hD1);
      drive(PH_LAST,  128'd4, 128'hA4, 128'hD2);
      idle(4);
      chk("t1.count", 128'(cap.size()), 128'd6);
      exp_rec("t1.w0", 0, {IV_A, 32'd0}, 128'hA0, 2'b00, 1'b0);
      exp_rec("t1.w1", 1, {IV_A, 32'd0}, 128'hA1, 2'b00, 1'b0);
      exp_rec("t1.w2", 2, {IV_A, 32'd2}, 128'hD0, 2'b01, 1'b0);
      exp_rec("t1.w3", 3, {IV_A, 32'd3}, 128'hD1, 2'b01, 1'b0);
      exp_rec("t1.w4", 4, {IV_A, 32'd4}, 128'hD2, 2'b01, 1'b0);
      exp_rec("t1.w5", 5, {IV_A, 32'd1}, 128'd0,  2'b10, 1'b1);

      // 2: single text block, no AAD; J0 directly behind it
      cap.delete(); isize = {64'd0, 64'd128};
      drive(PH_ONLY, 128'd0, 128'h0, 128'hE0);
      chk("t2.text.ctr", bus.o_ctr_block, {IV_A, 32'd2});
      chk("t2.text.kind_last", 128'({bus.o_kind, bus.o_last}), 128'(3'b010));
      tick();
      chk("t2.j0.ctr", bus.o_ctr_block, {IV_A, 32'd1});
      chk("t2.j0.kind_last", 128'({bus.o_kind, bus.o_last}), 128'(3'b101));
      idle(3);
      chk("t2.count", 128'(cap.size()), 128'd2);

      // 6: instance A closes, instance B's AAD arrives in A's TAG cycle
      cap.delete(); iv = IV_A; isize = {64'd0, 64'd128};
      drive(PH_ONLY, 128'd0, 128'h0, 128'hBA);
      iv = IV_B; isize = {64'd128, 64'd128};
      drive(PH_AAD,  128'd0, 128'hAB, 128'h0);
      drive(PH_ONLY, 128'd1, 128'h0, 128'hBB);
      idle(5);
      chk("t6.count", 128'(cap.size()), 128'd5);
      exp_rec("t6.a_text", 0, {IV_A, 32'd2}, 128'hBA, 2'b01, 1'b0);
      exp_rec("t6.a_j0",   1, {IV_A, 32'd1}, 128'd0,  2'b10, 1'b1);
      exp_rec("t6.b_aad",  2, {IV_B, 32'd0}, 128'hAB, 2'b00, 1'b0);
      exp_rec("t6.b_text", 3, {IV_B, 32'd2}, 128'hBB, 2'b01, 1'b0);
      exp_rec("t6.b_j0",   4, {IV_B, 32'd1}, 128'd0,  2'b10, 1'b1);
      chk("t6.overflow", 128'(overflow), 128'(1'b0));

      // 4: ctr32 wraps from FFFFFFFF to 0, upper counter bits ignored
      cap.delete(); iv = IV_A; isize = {64'd0, 64'd256};
      drive(PH_FIRST, 128'h5_FFFF_FFFD, 128'h0, 128'hC0);
      drive(PH_LAST,  128'h5_FFFF_FFFE, 128'h0, 128'hC1);
      idle(4);
      chk("t4.count", 128'(cap.size()), 128'd3);
      exp_rec("t4.max",  0, {IV_A, 32'hFFFF_FFFF}, 128'hC0, 2'b01, 1'b0);
      exp_rec("t4.wrap", 1, {IV_A, 32'd0},         128'hC1, 2'b01, 1'b0);
      exp_rec("t4.j0",   2, {IV_A, 32'd1},         128'd0,  2'b10, 1'b1);

      // 3: downstream stalled, 5th word dropped into full FIFO
      cap.delete(); bus.i_ready = 1'b0; isize = {64'd0, 64'd640};
      drive(PH_FIRST, 128'd0, 128'h0, 128'h10);
      chk("t3.head0", bus.o_ctr_block, {IV_A, 32'd2});
      drive(PH_TEXT, 128'd1, 128'h0, 128'h11);
      drive(PH_TEXT, 128'd2, 128'h0, 128'h12);
      drive(PH_TEXT, 128'd3, 128'h0, 128'h13);
      chk("t3.no_ovf_at_4", 128'(overflow), 128'(1'b0));
      drive(PH_TEXT, 128'd4, 128'h0, 128'h14);
      chk("t3.ovf_at_5", 128'(overflow), 128'(1'b1));
      chk("t3.head_stable", bus.o_data, 128'h10);
      idle(2);
      bus.i_ready = 1'b1;
      idle(6);
      chk("t3.ovf_sticky", 128'(overflow), 128'(1'b1));
      chk("t3.count", 128'(cap.size()), 128'd4);
      exp_rec("t3.w0", 0, {IV_A, 32'd2}, 128'h10, 2'b01, 1'b0);
      exp_rec("t3.w1", 1, {IV_A, 32'd3}, 128'h11, 2'b01, 1'b0);
      exp_rec("t3.w2", 2, {IV_A, 32'd4}, 128'h12, 2'b01, 1'b0);
      exp_rec("t3.w3", 3, {IV_A, 32'd5}, 128'h13, 2'b01, 1'b0);
`ifdef GCM_STATS_EN
      chk("stats.drop", 128'(drop_count), 128'd1);
      chk("stats.blk", 128'(blk_count), 128'd20);
`endif

      // 5: reset with three words queued, then a fresh instance
      bus.i_ready = 1'b0; isize = {64'd0, 64'd384};
      drive(PH_FIRST, 128'd0, 128'h0, 128'h20);
      drive(PH_TEXT,  128'd1, 128'h0, 128'h21);
      drive(PH_TEXT,  128'd2, 128'h0, 128'h22);
      chk("t5.queued", 128'(bus.o_valid), 128'(1'b1));
      rst_n = 1'b0;
      tick();
      chk("t5.rst.valid", 128'(bus.o_valid), 128'(1'b0));
      chk("t5.rst.overflow", 128'(overflow), 128'(1'b0));
      chk("t5.rst.ctr", bus.o_ctr_block, 128'd0);
      rst_n = 1'b1; bus.i_ready = 1'b1;
      cap.delete();
      tick();
      chk("t5.empty_after", 128'(bus.o_valid), 128'(1'b0));
      isize = {64'd0, 64'd128};
      drive(PH_ONLY, 128'd0, 128'h0, 128'h30);
      chk("t5.restart.ctr", bus.o_ctr_block, {IV_A, 32'd2});
      idle(4);
      chk("t5.count", 128'(cap.size()), 128'd2);
      exp_rec("t5.text", 0, {IV_A, 32'd2}, 128'h30, 2'b01, 1'b0);
      exp_rec("t5.j0",   1, {IV_A, 32'd1}, 128'd0,  2'b10, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
